// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce and a
// one-deep key register with valid/ready hand-off and a sticky overrun flag.
module keypad_scanner #(
    parameter int unsigned SCAN_TICKS   = 50000,
    parameter int unsigned DEBOUNCE_CNT = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overrun,
    input  logic       overrun_clr
);

    localparam int unsigned MAX_CNT = (SCAN_TICKS > DEBOUNCE_CNT) ? SCAN_TICKS : DEBOUNCE_CNT;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t           state;
    logic [3:0]       row_meta;
    logic [3:0]       rs;
    logic [1:0]       c;
    logic [1:0]       r;
    logic [CNT_W-1:0] cnt;
    logic             offer_c;

    // Active-low one-cold column drive for column index ci.
    function automatic logic [3:0] col_drive(input logic [1:0] ci);
        return ~(4'b0001 << ci);
    endfunction

    // Lowest-index row that reads low; only meaningful when some row is low.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        if (!v[0]) begin
            return 2'd0;
        end else if (!v[1]) begin
            return 2'd1;
        end else if (!v[2]) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

    // Two-flop synchronizer for the asynchronous, pulled-up row lines.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= 4'hF;
            rs       <= 4'hF;
        end else begin
            row_meta <= row;
            rs       <= row_meta;
        end
    end

    // A key is offered on the edge that completes the press debounce.
    always_comb begin
        offer_c = 1'b0;
        if ((state == DEBOUNCE) && !rs[r] && (cnt == DEB_LAST)) begin
            offer_c = 1'b1;
        end
    end

    // Scan / debounce / held state machine with registered column drive.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SCAN;
            c        <= 2'd0;
            r        <= 2'd0;
            cnt      <= '0;
            col      <= 4'b1110;
            key_held <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (rs == 4'hF) begin
                            c   <= c + 2'd1;
                            col <= col_drive(c + 2'd1);
                        end else begin
                            r     <= low_idx(rs);
                            state <= DEBOUNCE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DEBOUNCE: begin
                    if (rs[r]) begin
                        state <= SCAN;
                        c     <= 2'd0;
                        col   <= 4'b1110;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state    <= HELD;
                        cnt      <= '0;
                        key_held <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!rs[r]) begin
                        cnt <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state    <= SCAN;
                        c        <= 2'd0;
                        col      <= 4'b1110;
                        cnt      <= '0;
                        key_held <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state    <= SCAN;
                    c        <= 2'd0;
                    col      <= 4'b1110;
                    cnt      <= '0;
                    key_held <= 1'b0;
                end
            endcase
        end
    end

    // One-deep key register; a new key can replace one consumed on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (offer_c) begin
                if (!key_valid || key_ready) begin
                    key_code  <= {r, c};
                    key_valid <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end

            if (offer_c && key_valid && !key_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with short scan and debounce periods.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready = 1'b0;
    logic        key_held;
    logic        overrun;
    logic        overrun_clr = 1'b0;

    logic        use_matrix = 1'b0;
    logic [3:0]  row_force = 4'hF;
    logic [15:0] pressed = 16'h0000;
    logic [3:0]  mat_row;
    logic        chk_col = 1'b0;

    int checks = 0;
    int errors = 0;

    keypad_scanner #(.SCAN_TICKS(4), .DEBOUNCE_CNT(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .row        (row),
        .col        (col),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_held   (key_held),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // Keypad model: a pressed key at (i, j) pulls row i low while column j is driven low.
    always_comb begin
        mat_row = 4'hF;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (pressed[i*4+j] && (col[j] == 1'b0)) begin
                    mat_row[i] = 1'b0;
                end
            end
        end
    end

    assign row = use_matrix ? mat_row : row_force;

    typedef struct {
        logic       rst;
        logic [3:0] rw;
        logic       rdy;
        logic       clr;
        int         n;
        logic [3:0] e_col;
        logic       e_kv;
        logic [3:0] e_code;
        logic       e_held;
        logic       e_ovr;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, sample 1 time unit after the edge; col must stay one-cold.
    task automatic tick();
        @(posedge clk);
        #1;
        if (chk_col) begin
            checks++;
            if ($countones(~col) != 1) begin
                errors++;
                $display("FAIL col_one_cold: got %b expected exactly one low bit at %0t", col, $time);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_col = 1'b1;
    endtask

    task automatic wait_held(input logic v, input int budget, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (key_held === v) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: key_held got %b expected %b within %0d clocks", name, key_held, v, budget);
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (key_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: key_valid got %b expected 1 within %0d clocks", name, key_valid, budget);
        end
    endtask

    initial begin
        int n;

        // Reset and idle scan: column rotates every 4 clocks, key_ready ignored while empty.
        vt[0] = '{1'b1, 4'hF, 1'b0, 1'b0, 1,  4'hE, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[1] = '{1'b0, 4'hF, 1'b0, 1'b0, 3,  4'hE, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[2] = '{1'b0, 4'hF, 1'b1, 1'b0, 1,  4'hD, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[3] = '{1'b0, 4'hF, 1'b0, 1'b1, 4,  4'hB, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 4'hF, 1'b0, 1'b0, 4,  4'h7, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[5] = '{1'b0, 4'hF, 1'b1, 1'b1, 4,  4'hE, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[6] = '{1'b0, 4'hF, 1'b0, 1'b0, 3,  4'hE, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[7] = '{1'b0, 4'hF, 1'b0, 1'b0, 1,  4'hD, 1'b0, 4'h0, 1'b0, 1'b0};
        vt[8] = '{1'b0, 4'hF, 1'b0, 1'b0, 20, 4'hB, 1'b0, 4'h0, 1'b0, 1'b0};

        use_matrix = 1'b0;
        for (int v = 0; v < 9; v++) begin
            reset       = vt[v].rst;
            row_force   = vt[v].rw;
            key_ready   = vt[v].rdy;
            overrun_clr = vt[v].clr;
            for (int k = 0; k < vt[v].n; k++) begin
                tick();
            end
            chk_col = 1'b1;
            check($sformatf("vec%0d_col", v), col, vt[v].e_col);
            check($sformatf("vec%0d_valid", v), 4'(key_valid), 4'(vt[v].e_kv));
            check($sformatf("vec%0d_code", v), key_code, vt[v].e_code);
            check($sformatf("vec%0d_held", v), 4'(key_held), 4'(vt[v].e_held));
            check($sformatf("vec%0d_overrun", v), 4'(overrun), 4'(vt[v].e_ovr));
        end
        reset = 1'b0;
        key_ready = 1'b0;
        overrun_clr = 1'b0;

        // Bounce on row 1: never accepted, scanner stays on column 0 until the bounce ends.
        row_force = 4'hF;
        do_reset();
        for (int g = 0; g < 3; g++) begin
            row_force = 4'b1101;
            tick(); check("bounce_col", col, 4'hE); check("bounce_valid", 4'(key_valid), 4'h0);
            tick(); check("bounce_col", col, 4'hE); check("bounce_valid", 4'(key_valid), 4'h0);
            row_force = 4'hF;
            tick(); check("bounce_col", col, 4'hE); check("bounce_valid", 4'(key_valid), 4'h0);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bounce_settle_col", col, 4'hE);
        end
        tick();
        check("bounce_resume_col", col, 4'hD);
        check("bounce_no_key", 4'(key_valid), 4'h0);
        check("bounce_no_held", 4'(key_held), 4'h0);

        // Key 9 (row 2, column 1): accepted exactly 11 clocks after the reset edge.
        use_matrix = 1'b1;
        pressed = 16'h0200;
        do_reset();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            n++;
            if (key_valid === 1'b1) break;
        end
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL key9_latency: got %0d clocks expected 11", n);
        end
        check("key9_code", key_code, 4'h9);
        check("key9_held", 4'(key_held), 4'h1);
        check("key9_col", col, 4'hD);
        for (int k = 0; k < 6; k++) tick();
        check("key9_still_held", 4'(key_held), 4'h1);
        // Two-clock release glitch must not end the hold or produce a second key.
        pressed = 16'h0000;
        tick(); tick();
        pressed = 16'h0200;
        for (int k = 0; k < 5; k++) tick();
        check("glitch_held", 4'(key_held), 4'h1);
        check("glitch_overrun", 4'(overrun), 4'h0);
        check("glitch_valid", 4'(key_valid), 4'h1);
        // Real release: held drops on the fifth clock.
        pressed = 16'h0000;
        for (int k = 0; k < 4; k++) tick();
        check("release_held_early", 4'(key_held), 4'h1);
        tick();
        check("release_held", 4'(key_held), 4'h0);
        check("release_col", col, 4'hE);
        check("release_valid", 4'(key_valid), 4'h1);
        check("release_code", key_code, 4'h9);

        // Key 4 offered on the same edge key 9 is consumed: replaces it, no overrun.
        pressed = 16'h0010;
        for (int k = 0; k < 6; k++) tick();
        check("pre_offer_code", key_code, 4'h9);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("swap_valid", 4'(key_valid), 4'h1);
        check("swap_code", key_code, 4'h4);
        check("swap_overrun", 4'(overrun), 4'h0);
        check("swap_held", 4'(key_held), 4'h1);
        // Plain consume clears valid and keeps the code.
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("consume_valid", 4'(key_valid), 4'h0);
        check("consume_code", key_code, 4'h4);
        pressed = 16'h0000;
        wait_held(1'b0, 10, "key4_release");

        // Two presses without consuming: second is dropped and overrun sets.
        pressed = 16'h0001;
        do_reset();
        wait_valid(20, "key0_accept");
        check("key0_code", key_code, 4'h0);
        pressed = 16'h0000;
        wait_held(1'b0, 10, "key0_release");
        pressed = 16'h0020;
        wait_held(1'b1, 30, "key5_press");
        check("drop_valid", 4'(key_valid), 4'h1);
        check("drop_code", key_code, 4'h0);
        check("drop_overrun", 4'(overrun), 4'h1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check("clr_overrun", 4'(overrun), 4'h0);
        check("clr_keeps_code", key_code, 4'h0);
        pressed = 16'h0000;
        wait_held(1'b0, 10, "key5_release");
        // Clear held high across a drop: the set wins on that edge.
        overrun_clr = 1'b1;
        pressed = 16'h0004;
        wait_held(1'b1, 30, "key2_press");
        check("set_wins_overrun", 4'(overrun), 4'h1);
        overrun_clr = 1'b0;
        pressed = 16'h0000;
        wait_held(1'b0, 10, "key2_release");
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        check("drain_valid", 4'(key_valid), 4'h0);

        // Keys 7 and 15 together on column 3: lower row wins; then reset while held.
        pressed = 16'h8080;
        wait_held(1'b1, 30, "key7_press");
        check("multi_code", key_code, 4'h7);
        check("multi_valid", 4'(key_valid), 4'h1);
        check("multi_overrun", 4'(overrun), 4'h1);
        reset = 1'b1;
        tick();
        check("rst_col", col, 4'hE);
        check("rst_valid", 4'(key_valid), 4'h0);
        check("rst_code", key_code, 4'h0);
        check("rst_held", 4'(key_held), 4'h0);
        check("rst_overrun", 4'(overrun), 4'h0);
        reset = 1'b0;
        wait_valid(30, "redetect");
        check("redetect_code", key_code, 4'h7);
        check("redetect_held", 4'(key_held), 4'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The block SHALL have parameter SCAN_TICKS, default 50000, giving the clocks each column is driven before rows are sampled (minimum 4).
REQ-002 The block SHALL have parameter DEBOUNCE_CNT, default 250000, giving the consecutive stable clocks needed to accept a press or a release (minimum 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock for all logic (50 MHz board clock).
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port row, input, 4 bits: keypad row lines, active-low, pulled up, asynchronous to clk.
REQ-006 The block SHALL have port col, output, 4 bits: keypad column drive, active-low, exactly one bit low at all times.
REQ-007 The block SHALL have port key_code, output, 4 bits: accepted key, equal to row_index*4 + col_index.
REQ-008 The block SHALL have port key_valid, output, 1 bit: key_code holds an unconsumed key.
REQ-009 The block SHALL have port key_ready, input, 1 bit: the consumer accepts key_code on this edge when key_valid is 1.
REQ-010 The block SHALL have port key_held, output, 1 bit: an accepted key is still physically pressed.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag, set when a key was dropped.
REQ-012 The block SHALL have port overrun_clr, input, 1 bit: clears overrun.

Function
REQ-013 The row input SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value rs.
REQ-014 States SHALL be SCAN, DEBOUNCE and HELD.
REQ-015 In SCAN, col SHALL drive column c low while a dwell counter runs 0..SCAN_TICKS-1.
REQ-016 In SCAN, at dwell count SCAN_TICKS-1: if rs == 4'hF, c SHALL advance (3 wraps to 0) and the dwell counter SHALL clear; otherwise the FSM SHALL capture c and r and enter DEBOUNCE, keeping column c driven.
REQ-017 For capture, r SHALL be the lowest-index low bit of rs; for multiple rows low, the lowest index wins.
REQ-018 In DEBOUNCE, each clock SHALL count +1 while rs[r] == 0; any clock with rs[r] == 1 SHALL return to SCAN with c = 0 and the dwell counter cleared.
REQ-019 When DEBOUNCE reaches DEBOUNCE_CNT consecutive matches, the FSM SHALL enter HELD, and on that same edge the key SHALL be offered to the output register (REQ-022).
REQ-020 In HELD, key_held SHALL be 1 and column c SHALL stay driven; the counter SHALL count clocks with rs[r] == 1 and clear on any rs[r] == 0.
REQ-021 HELD SHALL exit to SCAN with c = 0 after DEBOUNCE_CNT consecutive release clocks; no auto-repeat SHALL occur, so one press yields one key.
REQ-022 Offer rules: if key_valid is 0, or (key_valid & key_ready) on the same edge, key_code SHALL load r*4 + c and key_valid SHALL be 1; otherwise the key SHALL be dropped, key_code/key_valid SHALL be unchanged, and overrun SHALL be set.
REQ-023 key_valid & key_ready with no offer SHALL clear key_valid on that edge; key_code SHALL hold its last value.
REQ-024 key_ready while key_valid is 0 SHALL be ignored.
REQ-025 overrun_clr SHALL clear overrun; a simultaneous set SHALL win over clear.
REQ-026 Counters SHALL be sized as ceil(log2(max(SCAN_TICKS, DEBOUNCE_CNT)+1)) bits and SHALL never wrap.

Reset
REQ-027 While reset is sampled high, on the next edge: state SHALL be SCAN, c SHALL be 0, col SHALL be 4'b1110, all counters SHALL be 0, key_code SHALL be 4'h0, and key_valid, key_held and overrun SHALL be 0.
REQ-028 The synchronizer flops SHALL reset to 1'b1 on all four bits.
REQ-029 Reset mid-DEBOUNCE or mid-HELD SHALL discard the press; a key still held after reset is released SHALL be re-detected as a new press.

Verification (SCAN_TICKS=4, DEBOUNCE_CNT=3)
REQ-030 Scenario: reset, then idle rows=4'hF for 40 clocks -> col cycles 1110, 1101, 1011, 0111 every 4 clocks; key_valid stays 0.
REQ-031 Scenario: row[2] low only while col==4'b1101, held for 20 clocks, key_ready=0 -> key_code=4'h9, key_valid=1 and key_held=1 within 4+2+3 clocks of first sample; after release and 3 stable clocks, key_held=0.
REQ-032 Scenario: bounce row[1] low for 2 clocks, high for 1, repeated 3 times -> no key_valid; FSM returns to SCAN with col=4'b1110 after each glitch.
REQ-033 Scenario: two full presses (keys 0x0 then 0x5) with key_ready=0 -> key_code=0x0, key_valid=1, overrun=1; pulse overrun_clr -> overrun=0.
REQ-034 Scenario: key_ready=1 on the same edge a second key is offered -> key_valid stays 1, key_code becomes the new code, overrun=0.
REQ-035 Scenario: rows 1 and 3 low together on column 3 -> key_code=4'h7; assert reset during HELD -> all outputs at reset values on the next edge.
